// File: rtl/counter_6_wrap_tally_pkg.sv
// rtl/counter_6_wrap_tally_pkg.sv - shared types and constants for the mod-6 wrap tally
package counter_6_wrap_tally_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_succ(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear priority and registered sat flag
module sat_counter #(
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [TALLY_W-1:0] value,
  output logic               sat
);

  localparam logic [TALLY_W-1:0] MAX = '1;

  logic [TALLY_W-1:0] value_nxt;

  always_comb begin
    value_nxt = value;
    if (clr)
      value_nxt = '0;
    else if (inc && (value != MAX))
      value_nxt = value + 1'b1;
  end

  // sat is registered from the next value so it tracks the tally register exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      sat   <= 1'b0;
    end else begin
      value <= value_nxt;
      sat   <= (value_nxt == MAX);
    end
  end

endmodule

// File: rtl/counter_6_wrap_tally.sv
// rtl/counter_6_wrap_tally.sv - counts 5->0 wraps of an upstream mod-6 counter and flags illegal codes
// Optional step checking enabled by COUNTER_6_WRAP_TALLY_STEP_CHECK_EN.
module counter_6_wrap_tally
  import counter_6_wrap_tally_pkg::*;
#(
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         cnt_in,
  input  logic               w_in,
  input  logic               clr,
  input  logic               err_ack,
  output logic [TALLY_W-1:0] tally,
  output logic               wrap_pulse,
  output logic               sat,
  output logic               err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_w;
  logic             wrap;
  logic             bad_code;
  logic             step_bad;

  assign bad_code = (cnt_in > CNT_MAX);

`ifdef COUNTER_6_WRAP_TALLY_STEP_CHECK_EN
  assign step_bad = prev_w ? (cnt_in != cnt_succ(prev_cnt)) : (cnt_in != prev_cnt);
`else
  logic unused_prev_w;
  assign unused_prev_w = prev_w;
  assign step_bad      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    wrap      = 1'b0;
    case (state)
      IDLE:  state_nxt = bad_code ? FAULT : TRACK;
      TRACK: begin
        // an illegal code or step violation wins over wrap detection
        if (bad_code || step_bad)
          state_nxt = FAULT;
        else
          wrap = (prev_cnt == CNT_MAX) && (cnt_in == '0);
      end
      FAULT: if (err_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_cnt   <= '0;
      prev_w     <= 1'b0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      wrap_pulse <= wrap;
      err        <= (state_nxt == FAULT);
      if (state != FAULT) begin
        prev_cnt <= cnt_in;
        prev_w   <= w_in;
      end
    end
  end

  sat_counter #(
    .TALLY_W(TALLY_W)
  ) u_sat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (wrap),
    .clr  (clr),
    .value(tally),
    .sat  (sat)
  );

endmodule

// File: tb/tb_counter_6_wrap_tally.sv
// tb/tb_counter_6_wrap_tally.sv - directed plus randomized check of counter_6_wrap_tally against a reference model
module tb_counter_6_wrap_tally;

  localparam int TW   = 2;
  localparam int TMAX = (1 << TW) - 1;
`ifdef COUNTER_6_WRAP_TALLY_STEP_CHECK_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, err_ack, w_in;
  logic [2:0]    cnt_in;
  logic [TW-1:0] tally;
  logic          wrap_pulse, sat, err;

  counter_6_wrap_tally #(.TALLY_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .w_in      (w_in),
    .clr       (clr),
    .err_ack   (err_ack),
    .tally     (tally),
    .wrap_pulse(wrap_pulse),
    .sat       (sat),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: history flag, fault flag, last sample, tally
  bit m_hist, m_fault, m_pulse, m_pw;
  int m_prev, m_tally;
  int sc;
  int pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit cl, input bit ak, input int c, input bit w);
    bit bad;
    int expect_c;
    if (r) begin
      m_hist = 0; m_fault = 0; m_prev = 0; m_pw = 0; m_tally = 0; m_pulse = 0;
    end else if (m_fault) begin
      m_pulse = 0;
      if (ak) begin m_fault = 0; m_hist = 0; end
      if (cl) m_tally = 0;
    end else if (!m_hist) begin
      m_hist = 1; m_fault = (c > 5); m_prev = c; m_pw = w; m_pulse = 0;
      if (cl) m_tally = 0;
    end else begin
      expect_c = m_pw ? (m_prev + 1) % 6 : m_prev;
      bad      = (c > 5) || (STEP && (c != expect_c));
      m_pulse  = !bad && (m_prev == 5) && (c == 0);
      m_fault  = bad;
      m_prev   = c;
      m_pw     = w;
      if (cl) m_tally = 0;
      else if (m_pulse && m_tally < TMAX) m_tally++;
    end
  endtask

  task automatic step(input bit r, input bit cl, input bit ak, input int c, input bit w);
    rst = r; clr = cl; err_ack = ak; cnt_in = c[2:0]; w_in = w;
    @(posedge clk);
    model(r, cl, ak, c, w);
    #1;
    check("tally", tally, m_tally);
    check("wrap_pulse", wrap_pulse, m_pulse);
    check("sat", sat, (m_tally == TMAX));
    check("err", err, m_fault);
    if (wrap_pulse) pulses++;
  endtask

  task automatic count_step(input bit w);
    step(0, 0, 0, sc, w);
    if (w) sc = (sc + 1) % 6;
  endtask

  initial begin
    int r, c;
    bit w, cl, ak, rs;
    rst = 1; clr = 0; err_ack = 0; cnt_in = 0; w_in = 0;
    pulses = 0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    check("rst_tally", tally, 0);
    check("rst_err", err, 0);

    // counter 0..5,0,1 with w_in=1
    sc = 0;
    for (int i = 0; i < 8; i++) begin
      count_step(1);
      if (i == 6) check("first_wrap_pulse", wrap_pulse, 1);
      if (i == 7) check("first_wrap_pulse_once", wrap_pulse, 0);
    end
    check("first_wrap_tally", tally, 1);
    check("first_wrap_err", err, 0);

    // four more wraps saturate the 2-bit tally
    for (int i = 0; i < 24; i++) count_step(1);
    check("five_wraps_pulses", pulses, 5);
    check("five_wraps_tally", tally, 3);
    check("five_wraps_sat", sat, 1);

    // illegal code in TRACK, then acknowledge
    step(0, 0, 0, 6, 1);
    check("illegal_err", err, 1);
    check("illegal_tally_held", tally, 3);
    step(0, 0, 0, 2, 1);
    check("fault_stays", err, 1);
    step(0, 0, 1, 0, 1);
    check("ack_err_clear", err, 0);
    check("ack_tally_kept", tally, 3);
    sc = 1;
    count_step(1);
    count_step(1);
    check("after_ack_err", err, 0);

    // clear on the same cycle as a wrap
    while (sc != 5) count_step(1);
    count_step(1);
    step(0, 1, 0, 0, 1);
    sc = 1;
    check("clr_wrap_tally", tally, 0);
    check("clr_wrap_pulse", wrap_pulse, 1);

    // skip 2->4 with w=1
    while (sc != 2) count_step(1);
    step(0, 0, 0, 2, 1);
    step(0, 0, 0, 4, 0);
    check("skip_err", err, STEP);
    step(0, 0, 1, 4, 0);

    // hold 3->3 with w=0 never faults
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    check("hold_no_err", err, 0);

    // reset mid-TRACK discards history of a pending 5
    sc = 3;
    step(0, 0, 0, 3, 1);
    count_step(1);
    count_step(1);
    count_step(1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("post_rst_no_wrap", wrap_pulse, 0);
    check("post_rst_tally", tally, 0);
    sc = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      rs = (r == 0);
      cl = ($urandom_range(0, 99) < 4);
      ak = ($urandom_range(0, 99) < 20);
      w  = ($urandom_range(0, 99) < 70);
      r  = $urandom_range(0, 99);
      if (r < 3) c = $urandom_range(6, 7);
      else if (r < 6) c = $urandom_range(0, 5);
      else c = sc;
      step(rs, cl, ak, c, w);
      if (c <= 5) sc = w ? (c + 1) % 6 : c;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_6_wrap_tally.md
COUNTER_6_WRAP_TALLY -- requirements
Module: counter_6_wrap_tally

Interface
REQ-001 SHALL have parameter: TALLY_W, 8, width of wrap tally (legal 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cnt_in  input  3  count value from the upstream mod-6 counter (legal 0..5).
REQ-005 SHALL have port: w_in  input  1  enable driven to the upstream counter, tapped in parallel.
REQ-006 SHALL have port: clr  input  1  synchronous tally clear.
REQ-007 SHALL have port: err_ack  input  1  fault acknowledge.
REQ-008 SHALL have port: tally  output  TALLY_W  number of detected 5->0 wraps.
REQ-009 SHALL have port: wrap_pulse  output  1  one-cycle pulse per detected wrap.
REQ-010 SHALL have port: sat  output  1  high while tally equals 2^TALLY_W-1.
REQ-011 SHALL have port: err  output  1  high while in FAULT.

Function
REQ-012 SHALL implement the FSM states IDLE, TRACK and FAULT; all outputs SHALL be registered.
REQ-013 IDLE: next cycle SHALL capture cnt_in into prev_cnt and w_in into prev_w; go TRACK if cnt_in<=5, else FAULT.
REQ-014 TRACK: cnt_in of 6 or 7 SHALL force FAULT on the next edge; prev_cnt/prev_w update every cycle.
REQ-015 TRACK: prev_cnt==5 and cnt_in==0 SHALL be a wrap; wrap_pulse SHALL be 1 on the cycle after the edge that sampled cnt_in==0 (latency 1), else 0.
REQ-016 Wrap SHALL increment tally by 1, saturating at 2^TALLY_W-1 (no wrap-around); sat SHALL follow the registered tally.
REQ-017 A wrap SHALL still pulse wrap_pulse when tally is saturated.
REQ-018 clr SHALL zero tally in any state; clr and wrap on the same cycle SHALL give tally=0, with wrap_pulse still asserted.
REQ-019 FAULT: err=1, wrap_pulse=0, tally frozen except for clr; err_ack SHALL return to IDLE (err=0 next cycle), and tally SHALL be retained.
REQ-020 err_ack outside FAULT SHALL be ignored.
REQ-021 A wrap and an illegal code cannot coincide; an illegal code SHALL take priority for state.

Reset
REQ-022 rst SHALL override clr and err_ack; on the next edge: state=IDLE, tally=0, wrap_pulse=0, sat=0, err=0, prev_cnt=0, prev_w=0.
REQ-023 rst asserted mid-TRACK or in FAULT SHALL discard history; the first post-reset sample SHALL NOT count as a wrap.

Configuration
REQ-024 Macro COUNTER_6_WRAP_TALLY_STEP_CHECK_EN SHALL enable step checking.
REQ-025 With the macro, in TRACK: if prev_w==1, cnt_in SHALL equal (prev_cnt+1) mod 6; if prev_w==0, cnt_in SHALL equal prev_cnt; any violation SHALL enter FAULT.
REQ-026 Without the macro, only codes 6/7 SHALL cause FAULT; holds, skips and jumps are accepted (a 5->0 jump still counts).

Structure
REQ-027 Package counter_6_wrap_tally_pkg SHALL hold the state enum, CNT_W=3 and CNT_MAX=5.
REQ-028 The saturating counter SHALL be sub-module sat_counter (parameter TALLY_W; inputs inc, clr; outputs value, sat).

Verification
REQ-029 rst 2 cycles, then w_in=1 with legal counter 0..5,0,1 -> one wrap_pulse one cycle after cnt_in=0, tally=1, err=0.
REQ-030 TALLY_W=2, 5 wraps -> tally 1,2,3,3,3; sat=1 from the third wrap; wrap_pulse on all 5.
REQ-031 cnt_in=6 in TRACK -> err=1 next cycle, tally held; err_ack=1 -> err=0, state IDLE then TRACK, tally unchanged.
REQ-032 clr on the same cycle wrap is detected with tally=3 -> tally=0, wrap_pulse=1.
REQ-033 With macro: prev_w=1, cnt 2->4 -> err=1; prev_w=0, cnt 3->3 -> no fault. Without macro: the same 2->4 gives no fault.
REQ-034 rst mid-TRACK while prev_cnt=5, cnt_in=0 after release -> no wrap_pulse, tally=0.
